// File: rtl/instruction_decode_if.sv
// ID-stage bus: IF/ID inputs, WB write port, stall, and the ID/EX latch outputs.
interface instruction_decode_if #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_REG  = 5
);
  logic [NB_DATA-1:0] i_instruction;
  logic [NB_DATA-1:0] i_pcounter4;
  logic               i_we_wb;
  logic               i_we;
  logic [NB_REG-1:0]  i_wr_addr;
  logic [NB_DATA-1:0] i_wr_data_WB;
  logic               i_stall;

  logic [NB_REG-1:0]  o_rs;
  logic [NB_REG-1:0]  o_rt;
  logic [NB_REG-1:0]  o_rd;
  logic [NB_DATA-1:0] o_reg_DA;
  logic [NB_DATA-1:0] o_reg_DB;
  logic [NB_DATA-1:0] o_immediate;
  logic [5:0]         o_opcode;
  logic [4:0]         o_shamt;
  logic [5:0]         o_func;
  logic [15:0]        o_addr;
  logic               o_jump;
  logic               o_branch;
  logic               o_regDst;
  logic               o_mem2Reg;
  logic               o_memRead;
  logic               o_memWrite;
  logic               o_immediate_flag;
  logic               o_regWrite;
  logic [1:0]         o_aluSrc;
  logic [1:0]         o_aluOp;

  modport master (
    output i_instruction, i_pcounter4, i_we_wb, i_we, i_wr_addr, i_wr_data_WB, i_stall,
    input  o_rs, o_rt, o_rd, o_reg_DA, o_reg_DB, o_immediate, o_opcode, o_shamt, o_func,
           o_addr, o_jump, o_branch, o_regDst, o_mem2Reg, o_memRead, o_memWrite,
           o_immediate_flag, o_regWrite, o_aluSrc, o_aluOp
  );

  modport slave (
    input  i_instruction, i_pcounter4, i_we_wb, i_we, i_wr_addr, i_wr_data_WB, i_stall,
    output o_rs, o_rt, o_rd, o_reg_DA, o_reg_DB, o_immediate, o_opcode, o_shamt, o_func,
           o_addr, o_jump, o_branch, o_regDst, o_mem2Reg, o_memRead, o_memWrite,
           o_immediate_flag, o_regWrite, o_aluSrc, o_aluOp
  );
endinterface

// File: rtl/instruction_decode.sv
// MIPS ID stage: field split, 32x32 register file with write-through, immediate
// extension, main control decode, all registered into the ID/EX latch.
// Field slicing and the jump target assume NB_DATA = 32 (MIPS32 encoding).
module instruction_decode #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_REG  = 5,
  parameter int unsigned N_REGS  = 32
) (
  input  logic                 clk,
  input  logic                 i_rst_n,   // active-high despite the name
  instruction_decode_if.slave  bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  logic [NB_DATA-1:0] instr;
  logic [5:0]         opcode;
  logic [5:0]         func;
  logic [NB_REG-1:0]  rs_f, rt_f, rd_f;
  logic               wr_en;

  assign instr  = bus.i_instruction;
  assign opcode = instr[31:26];
  assign func   = instr[5:0];
  assign rs_f   = instr[25:21];
  assign rt_f   = instr[20:16];
  assign rd_f   = instr[15:11];
  assign wr_en  = (bus.i_we_wb | bus.i_we) && (bus.i_wr_addr != '0);

  logic [NB_DATA-1:0] gpr_q [N_REGS];
  logic [NB_DATA-1:0] gpr_d [N_REGS];

  // Register file next state: single write port, r0 never written
  always_comb begin
    for (int i = 0; i < int'(N_REGS); i++) gpr_d[i] = gpr_q[i];
    if (wr_en) gpr_d[bus.i_wr_addr] = bus.i_wr_data_WB;
  end

  // Register file storage
  always_ff @(posedge clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      for (int i = 0; i < int'(N_REGS); i++) gpr_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(N_REGS); i++) gpr_q[i] <= gpr_d[i];
    end
  end

  logic [NB_DATA-1:0] rd_a, rd_b;

  // Read ports with write-through bypass; r0 reads zero
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (rs_f != '0) rd_a = (wr_en && rs_f == bus.i_wr_addr) ? bus.i_wr_data_WB : gpr_q[rs_f];
    if (rt_f != '0) rd_b = (wr_en && rt_f == bus.i_wr_addr) ? bus.i_wr_data_WB : gpr_q[rt_f];
  end

  logic [NB_REG-1:0]  rs_d, rt_d, rd_d, rs_q, rt_q, rd_q;
  logic [NB_DATA-1:0] da_d, db_d, imm_d, da_q, db_q, imm_q;
  logic [5:0]         opcode_d, func_d, opcode_q, func_q;
  logic [4:0]         shamt_d, shamt_q;
  logic [15:0]        addr_d, addr_q;
  logic               jump_d, branch_d, reg_dst_d, mem2reg_d, mem_read_d, mem_write_d;
  logic               imm_flag_d, reg_write_d;
  logic [1:0]         alu_src_d, alu_op_d;
  logic               jump_q, branch_q, reg_dst_q, mem2reg_q, mem_read_q, mem_write_q;
  logic               imm_flag_q, reg_write_q;
  logic [1:0]         alu_src_q, alu_op_q;
  logic               is_jalr;

  assign is_jalr = (opcode == OP_RTYPE) && (func == FN_JALR);

  // Fields, data path and immediate extension
  always_comb begin
    rs_d     = rs_f;
    rt_d     = rt_f;
    rd_d     = (opcode == OP_JAL) ? NB_REG'(31) : rd_f;
    opcode_d = opcode;
    func_d   = func;
    shamt_d  = instr[10:6];
    addr_d   = instr[15:0];
    da_d     = rd_a;
    db_d     = (opcode == OP_JAL || is_jalr) ? bus.i_pcounter4 : rd_b;
    imm_d    = {{(NB_DATA-16){instr[15]}}, instr[15:0]};
    case (opcode)
      OP_J, OP_JAL:             imm_d = {bus.i_pcounter4[31:28], instr[25:0], 2'b00};
      OP_ANDI, OP_ORI, OP_XORI: imm_d = {{(NB_DATA-16){1'b0}}, instr[15:0]};
      default:                  ;
    endcase
  end

  // Main control decode; stall forces a bubble
  always_comb begin
    jump_d      = 1'b0;
    branch_d    = 1'b0;
    reg_dst_d   = 1'b0;
    mem2reg_d   = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    imm_flag_d  = 1'b0;
    reg_write_d = 1'b0;
    alu_src_d   = 2'b00;
    alu_op_d    = 2'b00;
    case (opcode)
      OP_RTYPE: begin
        case (func)
          FN_JR:   jump_d = 1'b1;
          FN_JALR: begin
            jump_d      = 1'b1;
            reg_write_d = 1'b1;
            reg_dst_d   = 1'b1;
          end
          default: begin
            reg_dst_d   = 1'b1;
            reg_write_d = 1'b1;
            alu_op_d    = 2'b10;
            if (func == FN_SLL || func == FN_SRL || func == FN_SRA) alu_src_d = 2'b10;
          end
        endcase
      end
      6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b100111: begin
        mem_read_d  = 1'b1;
        mem2reg_d   = 1'b1;
        reg_write_d = 1'b1;
        alu_src_d   = 2'b01;
      end
      6'b101000, 6'b101001, 6'b101011: begin
        mem_write_d = 1'b1;
        alu_src_d   = 2'b01;
      end
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
        reg_write_d = 1'b1;
        imm_flag_d  = 1'b1;
        alu_src_d   = 2'b01;
        alu_op_d    = 2'b11;
      end
      OP_BEQ, OP_BNE: begin
        branch_d = 1'b1;
        alu_op_d = 2'b01;
      end
      OP_J:   jump_d = 1'b1;
      OP_JAL: begin
        jump_d      = 1'b1;
        reg_write_d = 1'b1;
      end
      default: ;
    endcase
    if (bus.i_stall) begin
      jump_d      = 1'b0;
      branch_d    = 1'b0;
      reg_dst_d   = 1'b0;
      mem2reg_d   = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      imm_flag_d  = 1'b0;
      reg_write_d = 1'b0;
      alu_src_d   = 2'b00;
      alu_op_d    = 2'b00;
    end
  end

  // ID/EX latch
  always_ff @(posedge clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      rs_q <= '0; rt_q <= '0; rd_q <= '0;
      da_q <= '0; db_q <= '0; imm_q <= '0;
      opcode_q <= '0; func_q <= '0; shamt_q <= '0; addr_q <= '0;
      jump_q <= 1'b0; branch_q <= 1'b0; reg_dst_q <= 1'b0; mem2reg_q <= 1'b0;
      mem_read_q <= 1'b0; mem_write_q <= 1'b0; imm_flag_q <= 1'b0; reg_write_q <= 1'b0;
      alu_src_q <= 2'b00; alu_op_q <= 2'b00;
    end else begin
      rs_q <= rs_d; rt_q <= rt_d; rd_q <= rd_d;
      da_q <= da_d; db_q <= db_d; imm_q <= imm_d;
      opcode_q <= opcode_d; func_q <= func_d; shamt_q <= shamt_d; addr_q <= addr_d;
      jump_q <= jump_d; branch_q <= branch_d; reg_dst_q <= reg_dst_d; mem2reg_q <= mem2reg_d;
      mem_read_q <= mem_read_d; mem_write_q <= mem_write_d; imm_flag_q <= imm_flag_d;
      reg_write_q <= reg_write_d; alu_src_q <= alu_src_d; alu_op_q <= alu_op_d;
    end
  end

  assign bus.o_rs             = rs_q;
  assign bus.o_rt             = rt_q;
  assign bus.o_rd             = rd_q;
  assign bus.o_reg_DA         = da_q;
  assign bus.o_reg_DB         = db_q;
  assign bus.o_immediate      = imm_q;
  assign bus.o_opcode         = opcode_q;
  assign bus.o_shamt          = shamt_q;
  assign bus.o_func           = func_q;
  assign bus.o_addr           = addr_q;
  assign bus.o_jump           = jump_q;
  assign bus.o_branch         = branch_q;
  assign bus.o_regDst         = reg_dst_q;
  assign bus.o_mem2Reg        = mem2reg_q;
  assign bus.o_memRead        = mem_read_q;
  assign bus.o_memWrite       = mem_write_q;
  assign bus.o_immediate_flag = imm_flag_q;
  assign bus.o_regWrite       = reg_write_q;
  assign bus.o_aluSrc         = alu_src_q;
  assign bus.o_aluOp          = alu_op_q;

endmodule

// File: tb/tb_instruction_decode.sv
// Scoreboarded bench for instruction_decode: directed vectors push expected
// ID/EX contents; a monitor pops one entry per cycle after the capturing edge.
module tb_instruction_decode;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instruction_decode_if bus ();

  instruction_decode dut (
    .clk     (clk),
    .i_rst_n (rst),
    .bus     (bus)
  );

  // ctrl = {jump,branch,regDst,mem2Reg,memRead,memWrite,imm_flag,regWrite,aluSrc[1:0],aluOp[1:0]}
  localparam logic [11:0] C_NONE  = 12'b0000_0000_0000;
  localparam logic [11:0] C_RTYPE = 12'b0010_0001_0010;
  localparam logic [11:0] C_SHIFT = 12'b0010_0001_1010;
  localparam logic [11:0] C_JR    = 12'b1000_0000_0000;
  localparam logic [11:0] C_JALR  = 12'b1010_0001_0000;
  localparam logic [11:0] C_IALU  = 12'b0000_0011_0111;
  localparam logic [11:0] C_LOAD  = 12'b0001_1001_0100;
  localparam logic [11:0] C_STORE = 12'b0000_0100_0100;
  localparam logic [11:0] C_BR    = 12'b0100_0000_0001;
  localparam logic [11:0] C_J     = 12'b1000_0000_0000;
  localparam logic [11:0] C_JAL   = 12'b1000_0001_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] da;
    logic [31:0] db;
    logic [31:0] imm;
    logic [11:0] ctrl;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [11:0] act_ctrl;
  assign act_ctrl = {bus.o_jump, bus.o_branch, bus.o_regDst, bus.o_mem2Reg, bus.o_memRead,
                     bus.o_memWrite, bus.o_immediate_flag, bus.o_regWrite, bus.o_aluSrc,
                     bus.o_aluOp};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one ID input set and record what the latch must hold after the next edge
  task automatic drive_push(input logic [31:0] instr, input logic [31:0] pc4,
                            input logic we_wb, input logic we, input logic [4:0] wa,
                            input logic [31:0] wd, input logic stall, input logic [4:0] rd,
                            input logic [31:0] da, input logic [31:0] db,
                            input logic [31:0] imm, input logic [11:0] ctrl);
    exp_t e;
    bus.i_instruction = instr;
    bus.i_pcounter4   = pc4;
    bus.i_we_wb       = we_wb;
    bus.i_we          = we;
    bus.i_wr_addr     = wa;
    bus.i_wr_data_WB  = wd;
    bus.i_stall       = stall;
    e.instr = instr; e.rd = rd; e.da = da; e.db = db; e.imm = imm; e.ctrl = ctrl;
    sb.push_back(e);
  endtask

  task automatic vec(input logic [31:0] instr, input logic [31:0] pc4,
                     input logic we_wb, input logic we, input logic [4:0] wa,
                     input logic [31:0] wd, input logic stall, input logic [4:0] rd,
                     input logic [31:0] da, input logic [31:0] db,
                     input logic [31:0] imm, input logic [11:0] ctrl);
    @(negedge clk);
    drive_push(instr, pc4, we_wb, we, wa, wd, stall, rd, da, db, imm, ctrl);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.i_instruction = '0; bus.i_pcounter4 = '0; bus.i_we_wb = 1'b0; bus.i_we = 1'b0;
    bus.i_wr_addr = '0; bus.i_wr_data_WB = '0; bus.i_stall = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " fields"}, {17'd0, bus.o_rs, bus.o_rt, bus.o_rd}, 32'd0);
    chk({tag, " DA"}, bus.o_reg_DA, 32'd0);
    chk({tag, " DB"}, bus.o_reg_DB, 32'd0);
    chk({tag, " imm"}, bus.o_immediate, 32'd0);
    chk({tag, " op/sh/fn"}, {15'd0, bus.o_opcode, bus.o_shamt, bus.o_func}, 32'd0);
    chk({tag, " addr"}, {16'd0, bus.o_addr}, 32'd0);
    chk({tag, " ctrl"}, {20'd0, act_ctrl}, 32'd0);
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 20) begin
      @(posedge clk);
      k++;
    end
    #2;
    chk("scoreboard drained", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: the latch presents a new value every cycle; compare after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rs/rt/rd", {17'd0, bus.o_rs, bus.o_rt, bus.o_rd},
            {17'd0, e.instr[25:21], e.instr[20:16], e.rd});
        chk("reg_DA", bus.o_reg_DA, e.da);
        chk("reg_DB", bus.o_reg_DB, e.db);
        chk("immediate", bus.o_immediate, e.imm);
        chk("op/sh/fn", {15'd0, bus.o_opcode, bus.o_shamt, bus.o_func},
            {15'd0, e.instr[31:26], e.instr[10:6], e.instr[5:0]});
        chk("addr", {16'd0, bus.o_addr}, {16'd0, e.instr[15:0]});
        chk("ctrl", {20'd0, act_ctrl}, {20'd0, e.ctrl});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_instruction = '0; bus.i_pcounter4 = '0; bus.i_we_wb = 1'b0; bus.i_we = 1'b0;
    bus.i_wr_addr = '0; bus.i_wr_data_WB = '0; bus.i_stall = 1'b0;
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    //   instr         pc4           wewb we  wa     wd            st  rd     DA            DB            imm           ctrl
    vec(32'h00221821, 32'h00000004, 0, 0, 5'd0,  32'h0,        0, 5'd3,  32'h0,        32'h0,        32'h00001821, C_RTYPE); // ADDU
    vec(32'h00A01821, 32'h00000008, 1, 0, 5'd5,  32'hDEADBEEF, 0, 5'd3,  32'hDEADBEEF, 32'h0,        32'h00001821, C_RTYPE); // bypass r5
    vec(32'h00A51821, 32'h0000000C, 0, 0, 5'd0,  32'h0,        0, 5'd3,  32'hDEADBEEF, 32'hDEADBEEF, 32'h00001821, C_RTYPE); // stored r5
    vec(32'h00001821, 32'h00000010, 0, 1, 5'd0,  32'h00001234, 0, 5'd3,  32'h0,        32'h0,        32'h00001821, C_RTYPE); // write r0
    vec(32'h00001821, 32'h00000014, 0, 0, 5'd0,  32'h0,        0, 5'd3,  32'h0,        32'h0,        32'h00001821, C_RTYPE); // r0 still 0
    vec(32'h22220004, 32'h00000018, 0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        32'h0,        32'h00000004, C_IALU);  // ADDI +4
    vec(32'h2222FFFC, 32'h0000001C, 0, 0, 5'd0,  32'h0,        0, 5'd31, 32'h0,        32'h0,        32'hFFFFFFFC, C_IALU);  // ADDI -4
    vec(32'h3622FFFC, 32'h00000020, 0, 0, 5'd0,  32'h0,        0, 5'd31, 32'h0,        32'h0,        32'h0000FFFC, C_IALU);  // ORI zext
    vec(32'h08000010, 32'h00000004, 0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        32'h0,        32'h00000040, C_J);     // J 16
    vec(32'h0C000010, 32'h10000008, 0, 0, 5'd0,  32'h0,        0, 5'd31, 32'h0,        32'h10000008, 32'h10000040, C_JAL);   // JAL link
    vec(32'h8CA30008, 32'h00000028, 0, 0, 5'd0,  32'h0,        1, 5'd0,  32'hDEADBEEF, 32'h0,        32'h00000008, C_NONE);  // LW stalled
    vec(32'h8CA30008, 32'h00000028, 0, 0, 5'd0,  32'h0,        0, 5'd0,  32'hDEADBEEF, 32'h0,        32'h00000008, C_LOAD);  // LW
    vec(32'hACA30008, 32'h0000002C, 0, 0, 5'd0,  32'h0,        0, 5'd0,  32'hDEADBEEF, 32'h0,        32'h00000008, C_STORE); // SW
    vec(32'h10A50004, 32'h00000030, 0, 0, 5'd0,  32'h0,        0, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 32'h00000004, C_BR);    // BEQ
    vec(32'h00031080, 32'h00000034, 0, 0, 5'd0,  32'h0,        0, 5'd2,  32'h0,        32'h0,        32'h00001080, C_SHIFT); // SLL
    vec(32'h00A00008, 32'h00000038, 0, 0, 5'd0,  32'h0,        0, 5'd0,  32'hDEADBEEF, 32'h0,        32'h00000008, C_JR);    // JR
    vec(32'h00A0F809, 32'h00000100, 0, 0, 5'd0,  32'h0,        0, 5'd31, 32'hDEADBEEF, 32'h00000100, 32'hFFFFF809, C_JALR);  // JALR
    vec(32'hFC000000, 32'h00000040, 0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        32'h0,        32'h00000000, C_NONE);  // bad opcode
    vec(32'h00070021, 32'h00000044, 0, 1, 5'd7,  32'h0BADF00D, 0, 5'd0,  32'h0,        32'h0BADF00D, 32'h00000021, C_RTYPE); // bypass r7 via i_we
    idle();
    drain();

    // Asynchronous reset mid-run with live inputs: outputs clear without a clock edge
    bus.i_instruction = 32'h00A51821;
    rst = 1'b1;
    #1;
    chk_all_zero("async reset");
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("held reset");

    // First edge after release captures; registers r5/r7 were cleared by reset
    @(negedge clk);
    rst = 1'b0;
    drive_push(32'h00A70021, 32'h00000048, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 32'h0, 32'h00000021, C_RTYPE);
    idle();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
MIPS pipeline ID stage. Splits the IF/ID instruction into fields, reads the 32x32 register file and sign/zero-extends the immediate. Generates main control. Registers everything into the ID/EX latch. The write-back stage writes into the register file contained in this block.

Parameters:
NB_DATA, 32, data/register width
NB_REG, 5, register address width
N_REGS, 32, register count

Ports:
clk  in  1  clock; all state updates on rising edge
i_rst_n  in  1  asynchronous reset, active-high (asserted when 1 despite the name)
i_instruction  in  32  instruction from IF/ID
i_pcounter4  in  32  PC+4 of this instruction
i_we_wb  in  1  register-file write strobe from WB
i_we  in  1  register-file write strobe from debug/loader; write occurs if either strobe is 1
i_wr_addr  in  5  register-file write address
i_wr_data_WB  in  32  register-file write data
i_stall  in  1  hazard stall: inject bubble
o_rs, o_rt, o_rd  out  5  instr[25:21], [20:16], [15:11]; o_rd=31 for JAL
o_reg_DA  out  32  GPR[rs]
o_reg_DB  out  32  GPR[rt]; i_pcounter4 for JAL/JALR (link value)
o_immediate  out  32  extended imm; jump target for J/JAL
o_opcode  out  6  instr[31:26]
o_shamt  out  5  instr[10:6]
o_func  out  6  instr[5:0]
o_addr  out  16  instr[15:0]
o_jump, o_branch, o_regDst, o_mem2Reg, o_memRead, o_memWrite, o_immediate_flag, o_regWrite  out  1 each  control
o_aluSrc  out  2  00=reg B, 01=immediate, 10=shamt
o_aluOp  out  2  00=add, 01=sub/compare, 10=R-type func, 11=I-type opcode

Behaviour:
- Reset (async): all outputs 0. All 32 GPRs cleared to 0.
- GPR0 reads 0 always. Writes to address 0 are ignored.
- Register-file write on rising edge when (i_we_wb | i_we) and i_wr_addr≠0.
- Write-through bypass: if a read address equals i_wr_addr, the address is nonzero and a write is active in the same cycle, the read returns i_wr_data_WB.
- All outputs are registered. Values computed from inputs in cycle N appear after rising edge N, giving 1-cycle latency. Outputs update every cycle; there is no hold.
- i_stall=1: all control outputs (jump..aluOp) are registered as 0 (bubble). Field and data outputs still update.
- Immediate: sign-extended instr[15:0]. ANDI/ORI/XORI are zero-extended. J/JAL use {i_pcounter4[31:28], instr[25:0], 2'b00}.
- Control decode (unlisted signals are 0):
  - R-type 000000: regDst, regWrite, aluOp=10. SLL/SRL/SRA (func 000000/000010/000011) additionally use aluSrc=10. JR (func 001000): jump only, regWrite=0, aluOp=00. JALR (001001): jump, regWrite, regDst, aluOp=00.
  - Loads LB/LH/LW/LBU/LHU/LWU (100000/100001/100011/100100/100101/100111): memRead, mem2Reg, regWrite, aluSrc=01, aluOp=00.
  - Stores SB/SH/SW (101000/101001/101011): memWrite, aluSrc=01, aluOp=00.
  - ADDI/ADDIU/SLTI/SLTIU/ANDI/ORI/XORI/LUI (001000..001111): regWrite, immediate_flag, aluSrc=01, aluOp=11.
  - BEQ/BNE (000100/000101): branch, aluOp=01.
  - J (000010): jump. JAL (000011): jump, regWrite.
  - Any other opcode: all controls 0.
- Reset deasserted mid-operation: the first rising edge after deassertion captures the current inputs.

Test Plan:
- Reset: hold i_rst_n=1 for 10 cycles → every output 0. Read any register after release → 0.
- ADDU 0x00221821 → rs=1, rt=2, rd=3, shamt=0, func=0x21, regDst=1, regWrite=1, aluOp=10, aluSrc=00, others 0.
- ADDI 0x22220004 → rs=17, rt=2, o_immediate=0x00000004, regWrite=1, immediate_flag=1, aluSrc=01, aluOp=11. With imm 0xFFFC → o_immediate=0xFFFFFFFC. ORI imm 0xFFFC → o_immediate=0x0000FFFC.
- J 16 (0x08000010) with i_pcounter4=0x00000004 → jump=1, o_immediate=0x00000040, regWrite=0.
- Write r5=0xDEADBEEF via i_we_wb while decoding an instruction with rs=5 → o_reg_DA=0xDEADBEEF in the same pass (bypass). Attempt to write r0=0x1234 → later reads of r0 return 0.
- LW with i_stall=1 → all controls 0, o_rs/o_rt still reflect the instruction. Deassert stall → memRead=1, mem2Reg=1, regWrite=1.
